adc_lock_supervisor: RTL and testbench
======================================

Name: adc_lock_supervisor

Overview:
- Supervises the ADC clock MMCM lock. Takes the raw asynchronous locked signal, debounces it, and counts lock-loss events.
- Pulses the MMCM reset when lock is not acquired within a timeout, with bounded retries.
- Produces a 32-bit status word that feeds user_data_in of the adc_in_locked software register (opb_register_simulink2ppc).
- Sits between the ADC clocking block and the status register, in the OPB_Clk domain.

Parameters:
- SETTLE_CYCLES, 1024: consecutive synchronized-high cycles required before lock is declared.
- TIMEOUT_CYCLES, 65536: cycles spent in ACQUIRE without lock before an MMCM reset is issued.
- RST_PULSE_CYCLES, 16: width of the mmcm_rst pulse.
- MAX_RETRIES, 7: number of MMCM resets before FAILED is entered. Range 1..15.

Ports:
- OPB_Clk, in, 1: sole clock.
- OPB_Rst, in, 1: synchronous, active-high reset.
- adc_locked_async, in, 1: raw MMCM locked, asynchronous to OPB_Clk.
- clr_stats, in, 1: level from a control register. Acts on its rising edge only.
- mmcm_rst, out, 1: MMCM reset request, active high.
- locked_ok, out, 1: high while the state is LOCKED.
- lost_pulse, out, 1: one-cycle pulse on each lock loss from LOCKED.
- status_word, out, 32: drives user_data_in of the status register.

Behaviour:
- Clocking and reset:
  - One clock (OPB_Clk). Reset is synchronous and active-high (OPB_Rst). All flops clear on OPB_Rst.
  - Reset values: state=ACQUIRE, timer=0, retry_cnt=0, loss_cnt=0, mmcm_rst=0, locked_ok=0, lost_pulse=0, status_word=32'h1000_0000.
- Synchronizer:
  - adc_locked_async passes through a 2-flop synchronizer to give lk, adding 2 cycles of latency.
  - clr_stats is registered once; its edge is detected as (clr_q==0 && clr_stats==1).
- State codes: ACQUIRE=1, SETTLE=2, LOCKED=3, RESET_MMCM=4, FAILED=5.
- Timer rules: the timer clears on every state entry and increments each cycle while in a state.
- Transitions:
  - ACQUIRE:
    - lk=1 -> SETTLE.
    - timer==TIMEOUT_CYCLES-1 and retry_cnt<MAX_RETRIES -> RESET_MMCM, retry_cnt+1.
    - timer==TIMEOUT_CYCLES-1 and retry_cnt==MAX_RETRIES -> FAILED.
  - SETTLE:
    - lk=0 -> ACQUIRE. No loss count, no retry.
    - timer==SETTLE_CYCLES-1 with lk=1 -> LOCKED, retry_cnt cleared.
  - LOCKED:
    - lk=0 -> ACQUIRE, loss_cnt+1 (saturating at 255), lost_pulse=1 for exactly one cycle.
  - RESET_MMCM:
    - mmcm_rst=1 for exactly RST_PULSE_CYCLES cycles; lk is ignored throughout.
    - After timer==RST_PULSE_CYCLES-1 -> ACQUIRE.
  - FAILED:
    - mmcm_rst=0. The state holds until a clr_stats edge or OPB_Rst.
- clr_stats edge:
  - Clears loss_cnt and retry_cnt in the same cycle.
  - In FAILED, it also moves the state to ACQUIRE. In any other state, the state is unaffected.
- Simultaneous events: a clr_stats edge in the same cycle as a loss gives loss_cnt=0, not 1. The loss transition and lost_pulse still occur.
- Outputs: mmcm_rst, locked_ok and lost_pulse are registered, so they are valid in the first cycle of the new state.
- status_word layout (registered, same cycle as the state register):
  - [31:28] state code.
  - [27:24] retry_cnt.
  - [23:16] loss_cnt.
  - [15:2] zero.
  - [1] lk.
  - [0] locked_ok.
- Reset mid-operation: OPB_Rst during RESET_MMCM drops mmcm_rst in the next cycle; no partial pulse is extended.
- Widths:
  - Timer width is $clog2 of the maximum of (TIMEOUT_CYCLES, SETTLE_CYCLES, RST_PULSE_CYCLES).
  - retry_cnt is 4 bits; loss_cnt is 8 bits.

Decomposition:
- Package adc_lock_pkg:
  - State enum and its 4-bit codes.
  - status_word field LSB/width constants.
  - LOSS_CNT_W=8 and RETRY_CNT_W=4.
- One sub-module, adc_lock_sync: a 2-flop synchronizer with reset. Everything else is flat in the top.

Test Plan:
Bench parameters: SETTLE=8, TIMEOUT=32, RST_PULSE=4, MAX_RETRIES=2.
- Clean lock: release reset, drive adc_locked_async=1 at cycle 0 -> locked_ok rises at cycle 11, status_word=32'h3000_0003, mmcm_rst never high.
- Never locks: hold adc_locked_async=0 -> mmcm_rst high for cycles 32-35 and 68-71 -> FAILED at cycle 104, status_word=32'h5200_0000. A clr_stats edge then gives 32'h1000_0000 and the bench observes a fresh timeout.
- Lock loss: from LOCKED, drop the input for 20 cycles -> lost_pulse is one cycle wide, loss_cnt=1, state returns to ACQUIRE, then relocks with loss_cnt still 1.
- Glitch in SETTLE: high for 5 cycles, then low for 1 -> returns to ACQUIRE, loss_cnt=0, retry_cnt=0. Next stable high locks after the full 8 cycles.
- Saturation and clear: 260 loss events -> loss_cnt=255. A clr_stats edge coinciding with a loss -> loss_cnt=0 and lost_pulse still asserted.
- Reset mid-pulse: assert OPB_Rst during the 2nd mmcm_rst cycle -> mmcm_rst=0 next cycle, status_word=32'h1000_0000.

Source files
------------

// File: rtl/adc_lock_pkg.sv
// Shared types and constants for the ADC MMCM lock supervisor.
// State codes, counter widths and status word field positions.
package adc_lock_pkg;

    localparam int LOSS_CNT_W  = 8;
    localparam int RETRY_CNT_W = 4;

    typedef enum logic [3:0] {
        ST_ACQUIRE    = 4'd1,
        ST_SETTLE     = 4'd2,
        ST_LOCKED     = 4'd3,
        ST_RESET_MMCM = 4'd4,
        ST_FAILED     = 4'd5
    } state_t;

    localparam int SW_STATE_LSB = 28;
    localparam int SW_STATE_W   = 4;
    localparam int SW_RETRY_LSB = 24;
    localparam int SW_RETRY_W   = RETRY_CNT_W;
    localparam int SW_LOSS_LSB  = 16;
    localparam int SW_LOSS_W    = LOSS_CNT_W;
    localparam int SW_LK_BIT    = 1;
    localparam int SW_OK_BIT    = 0;

    function automatic logic [31:0] pack_status(
        input state_t                 st,
        input logic [RETRY_CNT_W-1:0] retry,
        input logic [LOSS_CNT_W-1:0]  loss,
        input logic                   lk,
        input logic                   ok
    );
        logic [31:0] w;
        w = '0;
        w[SW_STATE_LSB +: SW_STATE_W] = st;
        w[SW_RETRY_LSB +: SW_RETRY_W] = retry;
        w[SW_LOSS_LSB +: SW_LOSS_W]   = loss;
        w[SW_LK_BIT]                  = lk;
        w[SW_OK_BIT]                  = ok;
        return w;
    endfunction

endpackage

// File: rtl/adc_lock_sync.sv
// Two-flop synchronizer with synchronous reset.
// Brings the raw MMCM locked level into the OPB_Clk domain.
module adc_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/adc_lock_supervisor.sv
// MMCM lock supervisor: debounce, loss counting, timed reset retries.
// Produces the status word read back through the software register.
module adc_lock_supervisor
    import adc_lock_pkg::*;
#(
    parameter int SETTLE_CYCLES    = 1024,
    parameter int TIMEOUT_CYCLES   = 65536,
    parameter int RST_PULSE_CYCLES = 16,
    parameter int MAX_RETRIES      = 7
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst,
    input  logic        adc_locked_async,
    input  logic        clr_stats,
    output logic        mmcm_rst,
    output logic        locked_ok,
    output logic        lost_pulse,
    output logic [31:0] status_word
);

    localparam int TMAX_A = (TIMEOUT_CYCLES > SETTLE_CYCLES) ?
                            TIMEOUT_CYCLES : SETTLE_CYCLES;
    localparam int TMAX   = (TMAX_A > RST_PULSE_CYCLES) ?
                            TMAX_A : RST_PULSE_CYCLES;
    localparam int TW     = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] T_TIMEOUT = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_SETTLE  = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] T_PULSE   = TW'(RST_PULSE_CYCLES - 1);

    localparam logic [RETRY_CNT_W-1:0] R_MAX = RETRY_CNT_W'(MAX_RETRIES);

    logic                   lk;
    logic                   clr_q;
    logic                   clr_edge;
    state_t                 state;
    state_t                 state_n;
    logic [TW-1:0]          timer;
    logic [TW-1:0]          timer_n;
    logic [RETRY_CNT_W-1:0] retry_cnt;
    logic [RETRY_CNT_W-1:0] retry_n;
    logic [LOSS_CNT_W-1:0]  loss_cnt;
    logic [LOSS_CNT_W-1:0]  loss_n;
    logic                   lost_n;

    adc_lock_sync u_sync (
        .clk (OPB_Clk),
        .rst (OPB_Rst),
        .d   (adc_locked_async),
        .q   (lk)
    );

    assign clr_edge = clr_stats & ~clr_q;

    // next state, counters and loss pulse
    always_comb begin
        state_n = state;
        retry_n = retry_cnt;
        loss_n  = loss_cnt;
        lost_n  = 1'b0;
        unique case (state)
            ST_ACQUIRE: begin
                if (lk) begin
                    state_n = ST_SETTLE;
                end else if (timer == T_TIMEOUT) begin
                    if (retry_cnt < R_MAX) begin
                        state_n = ST_RESET_MMCM;
                        retry_n = retry_cnt + 1'b1;
                    end else begin
                        state_n = ST_FAILED;
                    end
                end
            end
            ST_SETTLE: begin
                if (!lk) begin
                    state_n = ST_ACQUIRE;
                end else if (timer == T_SETTLE) begin
                    state_n = ST_LOCKED;
                    retry_n = '0;
                end
            end
            ST_LOCKED: begin
                if (!lk) begin
                    state_n = ST_ACQUIRE;
                    lost_n  = 1'b1;
                    if (loss_cnt != '1) begin
                        loss_n = loss_cnt + 1'b1;
                    end
                end
            end
            ST_RESET_MMCM: begin
                if (timer == T_PULSE) begin
                    state_n = ST_ACQUIRE;
                end
            end
            ST_FAILED: begin
                if (clr_edge) begin
                    state_n = ST_ACQUIRE;
                end
            end
            default: begin
                state_n = ST_ACQUIRE;
            end
        endcase
        // a clear wins over any same-cycle increment
        if (clr_edge) begin
            retry_n = '0;
            loss_n  = '0;
        end
        timer_n = (state_n != state) ? '0 : timer + 1'b1;
    end

    // state, counters and registered outputs
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state       <= ST_ACQUIRE;
            timer       <= '0;
            retry_cnt   <= '0;
            loss_cnt    <= '0;
            clr_q       <= 1'b0;
            mmcm_rst    <= 1'b0;
            locked_ok   <= 1'b0;
            lost_pulse  <= 1'b0;
            status_word <= 32'h1000_0000;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            retry_cnt   <= retry_n;
            loss_cnt    <= loss_n;
            clr_q       <= clr_stats;
            mmcm_rst    <= (state_n == ST_RESET_MMCM);
            locked_ok   <= (state_n == ST_LOCKED);
            lost_pulse  <= lost_n;
            status_word <= pack_status(state_n, retry_n, loss_n, lk,
                                       state_n == ST_LOCKED);
        end
    end

endmodule

// File: tb/tb_adc_lock_supervisor.sv
// Directed bench for adc_lock_supervisor with short timing parameters.
// Expected values are hand-computed cycle positions from reset release.
module tb_adc_lock_supervisor;

    logic        OPB_Clk = 1'b0;
    logic        OPB_Rst;
    logic        adc_locked_async;
    logic        clr_stats;
    logic        mmcm_rst;
    logic        locked_ok;
    logic        lost_pulse;
    logic [31:0] status_word;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    adc_lock_supervisor #(
        .SETTLE_CYCLES    (8),
        .TIMEOUT_CYCLES   (32),
        .RST_PULSE_CYCLES (4),
        .MAX_RETRIES      (2)
    ) dut (
        .OPB_Clk          (OPB_Clk),
        .OPB_Rst          (OPB_Rst),
        .adc_locked_async (adc_locked_async),
        .clr_stats        (clr_stats),
        .mmcm_rst         (mmcm_rst),
        .locked_ok        (locked_ok),
        .lost_pulse       (lost_pulse),
        .status_word      (status_word)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge OPB_Clk);
            #1;
            cyc++;
        end
    endtask

    task automatic go(input int t);
        while (cyc < t) tick(1);
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        OPB_Rst = 1'b1;
        adc_locked_async = 1'b0;
        clr_stats = 1'b0;
        tick(3);
        OPB_Rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        logic seen;
        logic got;
        int   n;

        // reset state
        OPB_Rst = 1'b1;
        adc_locked_async = 1'b0;
        clr_stats = 1'b0;
        tick(3);
        chk32("rst_status", status_word, 32'h1000_0000);
        chk1("rst_mmcm", mmcm_rst, 1'b0);
        chk1("rst_ok", locked_ok, 1'b0);
        chk1("rst_lost", lost_pulse, 1'b0);

        // clean lock
        OPB_Rst = 1'b0;
        cyc = 0;
        adc_locked_async = 1'b1;
        seen = 1'b0;
        while (cyc < 10) begin
            tick(1);
            seen = seen | mmcm_rst;
        end
        chk1("clean_ok_c10", locked_ok, 1'b0);
        tick(1);
        seen = seen | mmcm_rst;
        chk1("clean_ok_c11", locked_ok, 1'b1);
        chk32("clean_status", status_word, 32'h3000_0003);
        chk1("clean_no_mmcm", seen, 1'b0);

        // lock loss for 20 cycles, then relock
        adc_locked_async = 1'b0;
        tick(3);
        chk1("loss_pulse", lost_pulse, 1'b1);
        chk32("loss_status", status_word, 32'h1001_0000);
        tick(1);
        chk1("loss_pulse_1wide", lost_pulse, 1'b0);
        go(31);
        adc_locked_async = 1'b1;
        go(41);
        chk1("relock_c41", locked_ok, 1'b0);
        go(42);
        chk1("relock_ok", locked_ok, 1'b1);
        chk32("relock_status", status_word, 32'h3001_0003);

        // glitch while settling
        do_reset();
        adc_locked_async = 1'b1;
        go(3);
        chk32("gl_settle", status_word, 32'h2000_0002);
        go(5);
        adc_locked_async = 1'b0;
        go(6);
        adc_locked_async = 1'b1;
        go(8);
        chk32("gl_back_acq", status_word, 32'h1000_0000);
        go(9);
        chk32("gl_resettle", status_word, 32'h2000_0002);
        go(16);
        chk1("gl_ok_c16", locked_ok, 1'b0);
        go(17);
        chk1("gl_ok_c17", locked_ok, 1'b1);
        chk32("gl_status", status_word, 32'h3000_0003);

        // never locks: two retries then FAILED
        do_reset();
        go(31);
        chk1("nl_mmcm_c31", mmcm_rst, 1'b0);
        go(32);
        chk1("nl_mmcm_c32", mmcm_rst, 1'b1);
        chk32("nl_st_c32", status_word, 32'h4100_0000);
        go(35);
        chk1("nl_mmcm_c35", mmcm_rst, 1'b1);
        go(36);
        chk1("nl_mmcm_c36", mmcm_rst, 1'b0);
        chk32("nl_st_c36", status_word, 32'h1100_0000);
        go(67);
        chk1("nl_mmcm_c67", mmcm_rst, 1'b0);
        go(68);
        chk1("nl_mmcm_c68", mmcm_rst, 1'b1);
        chk32("nl_st_c68", status_word, 32'h4200_0000);
        go(71);
        chk1("nl_mmcm_c71", mmcm_rst, 1'b1);
        go(72);
        chk1("nl_mmcm_c72", mmcm_rst, 1'b0);
        go(103);
        chk32("nl_st_c103", status_word, 32'h1200_0000);
        go(104);
        chk32("nl_failed", status_word, 32'h5200_0000);
        chk1("nl_fail_mmcm", mmcm_rst, 1'b0);
        go(114);
        chk32("nl_fail_hold", status_word, 32'h5200_0000);
        clr_stats = 1'b1;
        tick(1);
        chk32("nl_clr", status_word, 32'h1000_0000);
        go(146);
        chk1("nl_fresh_c146", mmcm_rst, 1'b0);
        go(147);
        chk1("nl_fresh_c147", mmcm_rst, 1'b1);
        chk32("nl_fresh_st", status_word, 32'h4100_0000);
        clr_stats = 1'b0;

        // reset during the second mmcm_rst cycle
        do_reset();
        go(33);
        chk1("mr_mmcm_on", mmcm_rst, 1'b1);
        OPB_Rst = 1'b1;
        tick(1);
        chk1("mr_mmcm_off", mmcm_rst, 1'b0);
        chk32("mr_status", status_word, 32'h1000_0000);
        OPB_Rst = 1'b0;
        cyc = 0;

        // loss counter saturation
        do_reset();
        for (int i = 0; i < 260; i++) begin
            adc_locked_async = 1'b1;
            n = 0;
            while (!locked_ok && n < 40) begin
                tick(1);
                n++;
            end
            chk1("sat_lock_wait", locked_ok, 1'b1);
            adc_locked_async = 1'b0;
            got = 1'b0;
            n = 0;
            while (!got && n < 10) begin
                tick(1);
                n++;
                got = lost_pulse;
            end
            chk1("sat_loss_wait", got, 1'b1);
        end
        chk32("sat_loss_cnt", {24'h0, status_word[23:16]}, 32'd255);

        // clear coinciding with a loss
        adc_locked_async = 1'b1;
        n = 0;
        while (!locked_ok && n < 40) begin
            tick(1);
            n++;
        end
        chk1("co_lock_wait", locked_ok, 1'b1);
        adc_locked_async = 1'b0;
        tick(2);
        clr_stats = 1'b1;
        tick(1);
        chk1("co_lost", lost_pulse, 1'b1);
        chk32("co_status", status_word, 32'h1000_0000);
        tick(1);
        chk1("co_lost_end", lost_pulse, 1'b0);
        clr_stats = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
